// File: rtl/disp_capture_pkg.sv
// Shared types and constants for the display-stream capture block:
// FSM state encoding, colour packing width and pixel-limit helper.
package disp_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_CAPTURE    = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  localparam int unsigned CHANNELS = 3;

  function automatic int unsigned pix_limit(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/disp_capture_if.sv
// Display input bus plus the addressed write port of the capture block.
interface disp_capture_if #(
  parameter int BPC   = 5,
  parameter int CORDW = 16,
  parameter int ADDRW = 18
);
  logic signed [CORDW-1:0] disp_x;
  logic signed [CORDW-1:0] disp_y;
  logic                    disp_de;
  logic                    disp_frame;
  logic [BPC-1:0]          disp_r;
  logic [BPC-1:0]          disp_g;
  logic [BPC-1:0]          disp_b;

  // Write port: a beat moves on a clock edge with mem_valid && mem_ready.
  // Once mem_valid rises, mem_valid/mem_addr/mem_data hold until that beat
  // moves; mem_ready may be high at any time and alone has no effect.
  logic                    mem_valid;
  logic                    mem_ready;
  logic [ADDRW-1:0]        mem_addr;
  logic [3*BPC-1:0]        mem_data;

  modport master (
    input  disp_x, disp_y, disp_de, disp_frame, disp_r, disp_g, disp_b,
    input  mem_ready,
    output mem_valid, mem_addr, mem_data
  );

  modport slave (
    output disp_x, disp_y, disp_de, disp_frame, disp_r, disp_g, disp_b,
    output mem_ready,
    input  mem_valid, mem_addr, mem_data
  );
endinterface

// File: rtl/disp_cap_fifo.sv
// First-word-fall-through FIFO: rdata shows the head whenever empty is low.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module disp_cap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (count == (AW+1)'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/disp_capture.sv
// Captures one frame of a rectangular pixel window on request and emits each
// pixel as an addressed write beat through a small FWFT FIFO.
module disp_capture
  import disp_capture_pkg::*;
#(
  parameter int BPC        = 5,
  parameter int CORDW      = 16,
  parameter int ADDRW      = 18,
  parameter int WIN_WIDTH  = 672,
  parameter int WIN_HEIGHT = 384,
  parameter int WIN_STARTX = 0,
  parameter int WIN_STARTY = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  disp_capture_if.master   bus,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output state_e           dbg_state
);
  localparam int DW = int'(CHANNELS) * BPC;
  localparam int FW = ADDRW + DW;
  localparam int unsigned PIX_MAX = pix_limit(WIN_WIDTH, WIN_HEIGHT);
  localparam logic [ADDRW:0] CNT_MAX  = (ADDRW+1)'(PIX_MAX);
  localparam logic [ADDRW:0] LAST_IDX = (ADDRW+1)'(PIX_MAX - 1);
  localparam logic signed [CORDW:0] X_LO = (CORDW+1)'(WIN_STARTX);
  localparam logic signed [CORDW:0] X_HI = (CORDW+1)'(WIN_STARTX + WIN_WIDTH);
  localparam logic signed [CORDW:0] Y_LO = (CORDW+1)'(WIN_STARTY);
  localparam logic signed [CORDW:0] Y_HI = (CORDW+1)'(WIN_STARTY + WIN_HEIGHT);

  state_e                    state_q, state_d;
  logic [ADDRW:0]            count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic signed [CORDW:0]     x_s, y_s;
  logic                      in_win, push_req, pop;
  logic [FW-1:0]             fifo_wdata, fifo_rdata;
  logic                      fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Sign-extend one bit so the window bounds never overflow the compare.
  always_comb begin
    x_s        = {bus.disp_x[CORDW-1], bus.disp_x};
    y_s        = {bus.disp_y[CORDW-1], bus.disp_y};
    in_win     = bus.disp_de && (x_s >= X_LO) && (x_s < X_HI)
                             && (y_s >= Y_LO) && (y_s < Y_HI);
    push_req   = (state_q == ST_CAPTURE) && !bus.disp_frame && in_win
                 && (count_q != CNT_MAX);
    pop        = !fifo_empty && bus.mem_ready;
    fifo_wdata = {count_q[ADDRW-1:0], bus.disp_r, bus.disp_g, bus.disp_b};
  end

  disp_cap_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (arm) state_d = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (bus.disp_frame) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (bus.disp_frame)                          state_d = ST_DRAIN;
        else if (push_req && (count_q == LAST_IDX)) state_d = ST_DRAIN;
      end
      ST_DRAIN:      if (fifo_count == '0) state_d = ST_DONE;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // The address counter advances even when the FIFO drops the pixel.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if ((state_q == ST_IDLE) && arm) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (push_req) begin
      count_d = count_q + 1'b1;
      if (fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    overflow      = overflow_q;
    dbg_state     = state_q;
    bus.mem_valid = !fifo_empty;
    bus.mem_addr  = fifo_empty ? '0 : fifo_rdata[FW-1:DW];
    bus.mem_data  = fifo_empty ? '0 : fifo_rdata[DW-1:0];
  end

endmodule

// File: tb/tb_disp_capture.sv
// Directed bench for disp_capture: a 4x2 window at x=1 with a 4-entry FIFO,
// table-driven single-pixel vectors plus hand-written frame sequences.
module tb_disp_capture;
  import disp_capture_pkg::*;

  localparam int BPC = 5;
  localparam int CORDW = 16;
  localparam int ADDRW = 3;
  localparam int DW = 3 * BPC;
  localparam int W = ADDRW + DW;

  typedef struct {
    int             x;
    int             y;
    bit             de;
    logic [BPC-1:0] r;
    logic [BPC-1:0] g;
    logic [BPC-1:0] b;
    bit             hit;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   arm = 1'b0;
  logic   busy, done, overflow;
  state_e dbg_state;

  disp_capture_if #(.BPC(BPC), .CORDW(CORDW), .ADDRW(ADDRW)) bus ();

  disp_capture #(
    .BPC(BPC), .CORDW(CORDW), .ADDRW(ADDRW),
    .WIN_WIDTH(4), .WIN_HEIGHT(2), .WIN_STARTX(1), .WIN_STARTY(0),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int beats = 0;
  int dones = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0: ready high, 1: toggle, 2: ready low
  int last_xfer_cyc = 0;
  int done_cyc = 0;
  bit prev_pend = 1'b0;
  logic [W-1:0] prev_beat;
  logic [W-1:0] exp_q[$];
  vec_t vecs[10];

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.mem_ready = 1'b1;
      1:       bus.mem_ready = ~bus.mem_ready;
      default: bus.mem_ready = 1'b0;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input bit de,
                         input logic [BPC-1:0] r, input logic [BPC-1:0] g, input logic [BPC-1:0] b);
    bus.disp_x  = 16'(x);
    bus.disp_y  = 16'(y);
    bus.disp_de = de;
    bus.disp_r  = r;
    bus.disp_g  = g;
    bus.disp_b  = b;
  endtask

  task automatic expect_frame(input int n);
    logic [BPC-1:0] v;
    for (int a = 0; a < n; a++) begin
      v = 5'(1 + (a % 4) + 8 * (a / 4));
      exp_q.push_back({3'(a), v, v, v});
    end
  endtask

  task automatic do_arm();
    check("busy_pre_arm", 32'(busy), 32'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("busy_post_arm", 32'(busy), 32'd1);
  endtask

  task automatic frame_pulse(input int x, input int y, input bit de);
    set_pix(x, y, de, 5'd30, 5'd30, 5'd30);
    bus.disp_frame = 1'b1;
    tick();
    bus.disp_frame = 1'b0;
    set_pix(-2, 0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Lines y=0..2, x=-1..5, colour x+8y, de high for x>=0, then blanking.
  task automatic drive_frame(input int blank, input bit lat_chk, input bit arm_mid);
    logic [BPC-1:0] v;
    frame_pulse(-1, -1, 1'b0);
    for (int y = 0; y < 3; y++) begin
      for (int x = -1; x <= 5; x++) begin
        v = 5'(x + 8 * y);
        set_pix(x, y, (x >= 0), v, v, v);
        arm = arm_mid && (y == 0) && (x == 2);
        tick();
        if (lat_chk && (y == 0) && (x == 1)) begin
          check("first_valid", 32'(bus.mem_valid), 32'd1);
          check("first_addr", 32'(bus.mem_addr), 32'd0);
        end
      end
      arm = 1'b0;
      for (int b = 0; b < blank; b++) begin
        set_pix(-2, y, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
      end
    end
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; (k < 300) && (dones == d0); k++) @(negedge clk);
    repeat (3) tick();
    check("done_count", 32'(dones - d0), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("beats_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend)
        check("beat_hold", 32'({bus.mem_valid, bus.mem_addr, bus.mem_data}), 32'({1'b1, prev_beat}));
      if (bus.mem_valid && bus.mem_ready) begin
        beats++;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_extra: got %0h, expected no beat", {bus.mem_addr, bus.mem_data});
        end else begin
          check("beat", 32'({bus.mem_addr, bus.mem_data}), 32'(exp_q.pop_front()));
        end
      end
      prev_pend = bus.mem_valid && !bus.mem_ready;
      prev_beat = {bus.mem_addr, bus.mem_data};
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0, b0, bad;
    bus.disp_frame = 1'b0;
    bus.mem_ready  = 1'b1;
    set_pix(-2, 0, 1'b0, 5'd0, 5'd0, 5'd0);

    vecs[0] = '{1,      0,  1'b1, 5'd3,  5'd5,  5'd7,  1'b1};
    vecs[1] = '{0,      0,  1'b1, 5'd1,  5'd1,  5'd1,  1'b0};
    vecs[2] = '{4,      1,  1'b1, 5'd31, 5'd0,  5'd16, 1'b1};
    vecs[3] = '{5,      1,  1'b1, 5'd2,  5'd2,  5'd2,  1'b0};
    vecs[4] = '{2,      2,  1'b1, 5'd4,  5'd4,  5'd4,  1'b0};
    vecs[5] = '{2,      -1, 1'b1, 5'd6,  5'd6,  5'd6,  1'b0};
    vecs[6] = '{3,      1,  1'b0, 5'd9,  5'd9,  5'd9,  1'b0};
    vecs[7] = '{-32768, 0,  1'b1, 5'd1,  5'd2,  5'd3,  1'b0};
    vecs[8] = '{-3,     1,  1'b1, 5'd1,  5'd2,  5'd3,  1'b0};
    vecs[9] = '{1,      1,  1'b1, 5'd21, 5'd10, 5'd5,  1'b1};

    #12;
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single-pixel vectors; the in-window pixel on each frame pulse must not be captured.
    for (int i = 0; i < 10; i++) begin
      d0 = dones;
      b0 = beats;
      if (vecs[i].hit) exp_q.push_back({3'd0, vecs[i].r, vecs[i].g, vecs[i].b});
      do_arm();
      frame_pulse(1, 0, 1'b1);
      set_pix(vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].r, vecs[i].g, vecs[i].b);
      tick();
      set_pix(-2, 0, 1'b0, 5'd0, 5'd0, 5'd0);
      repeat (2) tick();
      frame_pulse(1, 0, 1'b1);
      wait_done(d0);
      check("vec_beats", 32'(beats - b0), 32'(vecs[i].hit));
    end

    // Full-rate capture
    d0 = dones;
    b0 = beats;
    expect_frame(8);
    do_arm();
    drive_frame(2, 1'b1, 1'b0);
    wait_done(d0);
    check("full_beats", 32'(beats - b0), 32'd8);
    check("full_overflow", 32'(overflow), 32'd0);
    check("done_latency", 32'(done_cyc - last_xfer_cyc), 32'd2);

    // Back-pressure without loss
    ready_mode = 1;
    d0 = dones;
    b0 = beats;
    expect_frame(8);
    do_arm();
    drive_frame(4, 1'b0, 1'b0);
    wait_done(d0);
    check("bp_beats", 32'(beats - b0), 32'd8);
    check("bp_overflow", 32'(overflow), 32'd0);

    // Overflow: nothing drains until after the frame
    ready_mode = 2;
    tick();
    d0 = dones;
    b0 = beats;
    expect_frame(4);
    do_arm();
    drive_frame(2, 1'b0, 1'b0);
    check("ovf_no_done_yet", 32'(dones - d0), 32'd0);
    check("ovf_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
    ready_mode = 0;
    wait_done(d0);
    check("ovf_beats", 32'(beats - b0), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    d0 = dones;
    expect_frame(8);
    do_arm();
    check("ovf_cleared_by_arm", 32'(overflow), 32'd0);
    drive_frame(2, 1'b0, 1'b0);
    wait_done(d0);
    check("ovf_clean_after", 32'(overflow), 32'd0);

    // arm during CAPTURE is ignored
    d0 = dones;
    expect_frame(8);
    do_arm();
    drive_frame(2, 1'b0, 1'b1);
    wait_done(d0);
    repeat (3) tick();
    check("arm_mid_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("arm_mid_single_done", 32'(dones - d0), 32'd1);

    // Armed with no frame pulse for 1000 cycles
    d0 = dones;
    bad = 0;
    do_arm();
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (!busy || bus.mem_valid) bad++;
    end
    check("wait_frame_quiet", 32'(bad), 32'd0);
    check("wait_frame_state", 32'(dbg_state), 32'(ST_WAIT_FRAME));
    expect_frame(8);
    drive_frame(2, 1'b0, 1'b0);
    wait_done(d0);

    // Reset in the middle of a capture with three beats queued
    ready_mode = 2;
    tick();
    do_arm();
    frame_pulse(-1, -1, 1'b0);
    for (int x = -1; x <= 3; x++) begin
      set_pix(x, 0, (x >= 0), 5'(x), 5'(x), 5'(x));
      tick();
    end
    set_pix(-2, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("mid_queued_valid", 32'(bus.mem_valid), 32'd1);
    d0 = dones;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.mem_valid), 32'd0);
    check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_data", 32'(bus.mem_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) tick();
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (5) tick();
    check("mid_rst_no_done", 32'(dones - d0), 32'd0);
    d0 = dones;
    b0 = beats;
    expect_frame(8);
    do_arm();
    drive_frame(2, 1'b1, 1'b0);
    wait_done(d0);
    check("rearm_beats", 32'(beats - b0), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
